// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Conditions raw board switch levels for the GPIO port block: each bit is
// brought into the clk domain through a two-flop synchroniser, then filtered
// by a per-bit stability counter that advances once per prescaler tick. A new
// level is accepted only after it has been seen on STABLE_TICKS consecutive
// ticks. Accepted changes produce one-cycle rise/fall pulses and a combined
// any_change strobe, all aligned with the cycle in which sw_db changes.
//
// Parameters:
//   WIDTH        number of switch bits
//   TICK_DIV     clk cycles per sample tick (>= 2)
//   STABLE_TICKS consecutive ticks a new level must persist (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         1 = debouncing active, 0 = prescaler/counters/outputs hold
//   sw_raw     raw switch levels, asynchronous to clk
//   sw_db      debounced registered levels
//   rise       one-cycle pulse per bit on an accepted 0->1 change
//   fall       one-cycle pulse per bit on an accepted 1->0 change
//   any_change one-cycle pulse when any bit of rise or fall is set
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    presc;
    logic             tick;

    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] db_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // Gating the tick with en keeps the counters frozen while disabled even
    // if the prescaler happens to be parked on its last value.
    assign tick = en && (presc == PRESC_LAST);

    // Per-bit stability counter. Any tick that sees the synchronised input
    // back at the accepted level restarts the count, so a bounce discards
    // the partial run. The pulse direction follows the newly accepted level,
    // which guarantees rise and fall are never set together for one bit.
    always_comb begin
        db_next   = sw_db;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (tick) begin
                if (sync2[i] == sw_db[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db_next[i]   = sync2[i];
                    cnt_next[i]  = '0;
                    rise_next[i] = sync2[i];
                    fall_next[i] = ~sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // The synchroniser runs regardless of en so that the debouncer sees a
    // current level the moment it is re-enabled. Pulses are registered from
    // the same next-state values that update sw_db, keeping them aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= '0;
            sync2      <= '0;
            presc      <= '0;
            sw_db      <= '0;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (en) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
            end
            sw_db      <= db_next;
            rise       <= rise_next;
            fall       <= fall_next;
            any_change <= |(rise_next | fall_next);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//
// Self-checking bench for switch_debouncer with WIDTH=8, TICK_DIV=4,
// STABLE_TICKS=3. Each stimulus pushes its expected accepted result onto a
// scoreboard queue; the record is popped and compared when the DUT raises
// any_change. Quiet windows confirm that no pulses appear where none are due.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_switch_debouncer;

    localparam int WIDTH        = 8;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    // A clean step is first sampled on edge 1 after it is driven and must be
    // accepted 10..13 edges later, i.e. on edge 11..14.
    localparam int STEP_MIN = 2 + (STABLE_TICKS - 1) * TICK_DIV + 1;
    localparam int STEP_MAX = 2 + STABLE_TICKS * TICK_DIV - 1 + 1;
    localparam int TIMEOUT  = 60;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_change;

    int n_checks;
    int n_fail;

    typedef struct {
        string      name;
        logic [7:0] db;
        logic [7:0] rise;
        logic [7:0] fall;
        int         min_lat;
        int         max_lat;
    } exp_t;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] db;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    switch_debouncer #(
        .WIDTH(WIDTH),
        .TICK_DIV(TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .rise(rise),
        .fall(fall),
        .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison with its own failure line.
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, req);
        end
    endtask

    task automatic pushExpect(input string name, input logic [7:0] db, input logic [7:0] r,
                              input logic [7:0] f, input int min_lat, input int max_lat);
        exp_t e;
        e.name    = name;
        e.db      = db;
        e.rise    = r;
        e.fall    = f;
        e.min_lat = min_lat;
        e.max_lat = max_lat;
        sb.push_back(e);
    endtask

    // Drives a clean step; caller is positioned just after a rising edge.
    task automatic applyStimulus(input string name, input logic [7:0] raw, input logic [7:0] db,
                                 input logic [7:0] r, input logic [7:0] f);
        pushExpect(name, db, r, f, STEP_MIN, STEP_MAX);
        sw_raw = raw;
    endtask

    // Waits for the next any_change, pops the scoreboard and compares.
    task automatic checkOutput();
        exp_t e;
        int   lat;
        bit   seen;
        e    = sb.pop_front();
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
            if (any_change === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: no any_change within %0d edges", e.name, TIMEOUT);
        end else begin
            n_checks++;
            if (lat < e.min_lat || lat > e.max_lat) begin
                n_fail++;
                $display("[TB] FAIL %s latency: got %0d edges, expected %0d..%0d",
                         e.name, lat, e.min_lat, e.max_lat);
            end
            check({e.name, " sw_db"}, sw_db, e.db);
            check({e.name, " rise"},  rise,  e.rise);
            check({e.name, " fall"},  fall,  e.fall);
            @(posedge clk);
            #1;
            check({e.name, " pulse end"}, {any_change, 7'b0} | rise | fall, 8'h00);
            check({e.name, " sw_db hold"}, sw_db, e.db);
        end
    endtask

    // No pulses for n cycles and sw_db stays at the given value.
    task automatic checkQuiet(input string name, input int n, input logic [7:0] db);
        int events;
        int db_bad;
        events = 0;
        db_bad = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (any_change !== 1'b0 || rise !== 8'h00 || fall !== 8'h00) events++;
            if (sw_db !== db) db_bad++;
        end
        check({name, " quiet pulses"}, 8'(events), 8'h00);
        check({name, " quiet sw_db"},  8'(db_bad), 8'h00);
    endtask

    initial begin
        int bounce_events;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{raw: 8'h01, db: 8'h01, rise: 8'h01, fall: 8'h00};
        vecs[1] = '{raw: 8'h00, db: 8'h00, rise: 8'h00, fall: 8'h01};
        vecs[2] = '{raw: 8'hA5, db: 8'hA5, rise: 8'hA5, fall: 8'h00};
        vecs[3] = '{raw: 8'h00, db: 8'h00, rise: 8'h00, fall: 8'hA5};
        vecs[4] = '{raw: 8'hFF, db: 8'hFF, rise: 8'hFF, fall: 8'h00};
        vecs[5] = '{raw: 8'h5A, db: 8'h5A, rise: 8'h00, fall: 8'hA5};
        vecs[6] = '{raw: 8'h00, db: 8'h00, rise: 8'h00, fall: 8'h5A};

        // Reset held with all switches high: everything must read zero.
        rst    = 1'b0;
        en     = 1'b1;
        sw_raw = 8'hFF;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset sw_db", sw_db, 8'h00);
        check("reset rise",  rise,  8'h00);
        check("reset fall",  fall,  8'h00);
        check("reset any_change", {7'b0, any_change}, 8'h00);

        sw_raw = 8'h00;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkQuiet("post reset", 20, 8'h00);

        $display("[TB] Table-driven clean steps");
        for (int v = 0; v < 7; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].raw, vecs[v].db, vecs[v].rise, vecs[v].fall);
            checkOutput();
            checkQuiet($sformatf("vec%0d hold", v), 20, vecs[v].db);
        end

        $display("[TB] Bounce on bit 3");
        bounce_events = 0;
        sw_raw = 8'h08;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (any_change !== 1'b0) bounce_events++;
        end
        sw_raw = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (any_change !== 1'b0) bounce_events++;
        end
        check("bounce early run", 8'(bounce_events), 8'h00);
        applyStimulus("bounce final", 8'h08, 8'h08, 8'h08, 8'h00);
        checkOutput();
        checkQuiet("bounce hold", 20, 8'h08);
        applyStimulus("bounce release", 8'h00, 8'h00, 8'h00, 8'h08);
        checkOutput();
        checkQuiet("bounce release hold", 10, 8'h00);

        $display("[TB] Short glitch on bit 5");
        sw_raw = 8'h20;
        @(posedge clk);
        #1;
        sw_raw = 8'h00;
        checkQuiet("glitch", 40, 8'h00);

        $display("[TB] Enable hold on bit 1");
        en     = 1'b0;
        sw_raw = 8'h02;
        checkQuiet("en low", 40, 8'h00);
        // Synchroniser already holds the new level; three ticks after en
        // returns land on edge 9..12 depending on the frozen prescaler phase.
        pushExpect("en resume", 8'h02, 8'h02, 8'h00, 2 * TICK_DIV + 1, 3 * TICK_DIV);
        en = 1'b1;
        checkOutput();
        checkQuiet("en resume hold", 10, 8'h02);
        applyStimulus("en release", 8'h00, 8'h00, 8'h00, 8'h02);
        checkOutput();

        $display("[TB] Reset mid-count");
        applyStimulus("pre reset set", 8'hFF, 8'hFF, 8'hFF, 8'h00);
        checkOutput();
        sw_raw = 8'h00;
        // Nine edges guarantee two ticks have counted but no acceptance yet.
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid reset sw_db async", sw_db, 8'h00);
        check("mid reset pulses", {any_change, 7'b0} | rise | fall, 8'h00);
        checkQuiet("in reset", 3, 8'h00);
        sw_raw = 8'hFF;
        @(posedge clk);
        #2;
        // Fresh count after release: ticks on edges 4, 8, 12, accept on 12.
        pushExpect("after reset", 8'hFF, 8'hFF, 8'h00, 3 * TICK_DIV, 3 * TICK_DIV);
        rst = 1'b1;
        checkOutput();
        checkQuiet("after reset hold", 20, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input conditioning stage directly upstream of the GPIO port block. It takes raw, asynchronous, bouncing board switch levels, synchronises them to `clk` and debounces them. It drives the clean levels onto the switch-side pins of port A/B, which the port reads when DDR bits are 0. It also produces per-bit edge pulses and a change strobe for future interrupt or event logic.

## Interface
Parameters:
- `WIDTH`, 8: number of switch bits handled; one instance per switch port.
- `TICK_DIV`, 50000: `clk` cycles per sample tick; must be ≥ 2.
- `STABLE_TICKS`, 10: consecutive ticks a new level must persist before it is accepted; must be ≥ 1.

Ports:
- `clk` in 1: system clock; all state is on its rising edge.
- `rst` in 1: reset, asynchronous, active-low; clears all state immediately while low.
- `en` in 1: 1 = debouncing active; 0 = prescaler and bit counters hold, outputs hold.
- `sw_raw` in `WIDTH`: raw switch levels, asynchronous to `clk`.
- `sw_db` out `WIDTH`: debounced, registered levels; feeds the port block's switch pins.
- `rise` out `WIDTH`: one-cycle pulse per bit when `sw_db[i]` goes 0→1.
- `fall` out `WIDTH`: one-cycle pulse per bit when `sw_db[i]` goes 1→0.
- `any_change` out 1: registered OR of all `rise` and `fall` bits in the same cycle.

## Operation
- **Synchroniser.** There is a two-flop chain per bit: `sync1 <= sw_raw`, then `sync2 <= sync1`. Only `sync2` is used downstream. No other logic reads `sw_raw`.
- **Prescaler.**
  - `presc` counts 0..`TICK_DIV`-1 when `en`=1, then wraps to 0.
  - `tick` is combinational, `presc == TICK_DIV-1` && `en`.
  - Width of `presc` is `$clog2(TICK_DIV)`.
- **Per-bit counter.** `cnt[i]` has width `$clog2(STABLE_TICKS+1)` and updates only on `tick`:
  - If `sync2[i] == sw_db[i]`, then `cnt[i] <= 0`. A bounce back to the old level restarts the count.
  - Otherwise, if `cnt[i] == STABLE_TICKS-1`, then `sw_db[i] <= sync2[i]`, `cnt[i] <= 0`, and the matching `rise[i]`/`fall[i]` goes to 1 for the next cycle.
  - Otherwise, `cnt[i] <= cnt[i] + 1`.
- **Independence.** Bits are fully independent. Several bits may accept changes on the same tick, and their `rise`/`fall` bits assert together.
- **Pulses.** `rise`, `fall` and `any_change` are registered and default to 0 every cycle unless set as above. A bit never has `rise` and `fall` high at once.
- **Glitch filtering.** Glitches shorter than one tick period may never be sampled. That is intended filtering.
- **`en` low.** `presc` and `cnt` freeze and no pulses are generated. The synchroniser keeps running.

## Timing
- **Reset values.** `sync1`, `sync2`, `presc`, `cnt`, `sw_db`, `rise`, `fall` and `any_change` are all 0. `sw_db` = 0 matches the port's input-mode reset default.
- **Reset mid-operation.** Any in-progress count is discarded and outputs drop to 0 asynchronously. After `rst` rises, the first tick occurs on the `TICK_DIV`-th rising edge.
- **Latency.** For a clean step on `sw_raw[i]`, `sw_db[i]` changes between 2+(`STABLE_TICKS`-1)·`TICK_DIV` and 2+`STABLE_TICKS`·`TICK_DIV`-1 clk edges after the first edge that samples the new level.
- **Pulse alignment.** `rise`/`fall`/`any_change` assert in the same cycle `sw_db` shows the new value, for exactly one cycle.
- **Wrap-around.** `presc` wraps at `TICK_DIV`-1. `cnt` never exceeds `STABLE_TICKS`-1, so it needs no wrap.
- **Fixed accept time.** A level held indefinitely after acceptance causes no further pulses. Throughput is one accepted change per bit per `STABLE_TICKS` ticks.

## Test plan
All scenarios use `WIDTH`=8, `TICK_DIV`=4, `STABLE_TICKS`=3.
- **Reset.** Hold `rst`=0 with `sw_raw`=8'hFF → all outputs 0. Assert `rst`=0 mid-count (after 2 accepted ticks) → `sw_db` and `cnt` clear at once, no pulse afterwards.
- **Clean step.** `sw_raw[0]` 0→1 held → `sw_db[0]`=1 within 10–13 edges; `rise[0]` and `any_change` high exactly 1 cycle; `fall`=0.
- **Bounce.** `sw_raw[3]`: 1 for 5 cycles, 0 for 5, then 1 held → the early run is discarded; `sw_db[3]` rises once, 10–13 edges after the final 1, with a single `rise[3]` pulse.
- **Short glitch.** `sw_raw[5]` pulses 1 for 1 cycle → `sw_db[5]` stays 0, no pulses.
- **Simultaneous and release.** 8'h00→8'hA5 simultaneously → `sw_db`=8'hA5 with `rise`=8'hA5 in one cycle. Then return to 8'h00 → `fall`=8'hA5, single `any_change` pulse each time.
- **Enable hold.** Set `en`=0 while `sw_raw[1]`=1 for 40 cycles → `sw_db[1]` stays 0. Then `en`=1 → change accepted after 3 ticks.
